// File: rtl/fas_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : fas_pkg
//  Description : Shared constants, result type and reference function for the
//                fas_cell full adder/subtractor bit-slice.
//  Revision    : 1.0  initial release
// ============================================================================
package fas_pkg;

   // Default gate propagation delays in ns (rise and fall identical)
   localparam int NAND_TPD = 10;
   localparam int XNOR_TPD = 9;
   localparam int OR_TPD   = 8;

   // Packed result: bit 1 = carry out, bit 0 = sum
   typedef logic [1:0] fas_res_t;

   // Arithmetic view of the slice: a + (a_ns ? b : ~b) + cin, two bits wide
   function automatic fas_res_t fas_ref(input logic a, input logic b,
                                        input logic cin, input logic a_ns);
      logic bx;
      bx = a_ns ? b : ~b;
      return {1'b0, a} + {1'b0, bx} + {1'b0, cin};
   endfunction

endpackage : fas_pkg
`default_nettype wire

// File: rtl/fas_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : fas_core
//  Description : Pure combinational add/subtract bit-slice built from
//                delay-annotated XNOR/OR/NAND gates.
//                sum path = 3 XNOR, carry path = XNOR + OR + 2 NAND.
//  Revision    : 1.0  initial release
// ============================================================================
module fas_core #(
   parameter int NAND_TPD = fas_pkg::NAND_TPD,
   parameter int XNOR_TPD = fas_pkg::XNOR_TPD,
   parameter int OR_TPD   = fas_pkg::OR_TPD
) (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic a_ns,
   output logic sum,
   output logic cy
);

   logic w_bx;        // b when adding, ~b when subtracting
   logic w_q;         // a ^ bx
   logic w_o;         // a | bx
   logic w_nand_ab;   // ~(a & bx)
   logic w_nand_co;   // ~(cin & (a | bx))

   // Operand conditioning: XNOR with a_ns passes b for add, inverts for subtract
   assign #(XNOR_TPD) w_bx = ~(b ^ a_ns);

   // Sum chain: XNOR(XNOR(a,bx),cin) equals a ^ bx ^ cin (two inversions cancel)
   assign #(XNOR_TPD) w_q  = ~(a ^ w_bx);
   assign #(XNOR_TPD) sum  = ~(w_q ^ cin);

   // Carry chain: maj(a,bx,cin) = (a&bx) | (cin&(a|bx)) in NAND-NAND form
   assign #(OR_TPD)   w_o       = a | w_bx;
   assign #(NAND_TPD) w_nand_ab = ~(a & w_bx);
   assign #(NAND_TPD) w_nand_co = ~(cin & w_o);
   assign #(NAND_TPD) cy        = ~(w_nand_ab & w_nand_co);

endmodule : fas_core
`default_nettype wire

// File: rtl/fas_cell.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : fas_cell
//  Description : 1-bit full adder/subtractor slice with registered outputs.
//                a_ns=1 : {cout,s} = a + b + cin
//                a_ns=0 : {cout,s} = a + ~b + cin (cin=1 means no borrow)
//                Optional behavioural self-check enabled by macro FAS_CHECK_EN.
//                Clock period must exceed the longest gate path
//                (XNOR + OR + 2*NAND with default delays).
//  Revision    : 1.0  initial release
// ============================================================================
module fas_cell #(
   parameter int NAND_TPD = fas_pkg::NAND_TPD,
   parameter int XNOR_TPD = fas_pkg::XNOR_TPD,
   parameter int OR_TPD   = fas_pkg::OR_TPD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic a_ns,
   output logic s,
   output logic cout
);

   import fas_pkg::*;

   logic     w_sum;
   logic     w_cy;
   fas_res_t res_d;
   fas_res_t res_q;

   fas_core #(
      .NAND_TPD (NAND_TPD),
      .XNOR_TPD (XNOR_TPD),
      .OR_TPD   (OR_TPD)
   ) u_core (
      .a    (a),
      .b    (b),
      .cin  (cin),
      .a_ns (a_ns),
      .sum  (w_sum),
      .cy   (w_cy)
   );

   // Pack the gate-network outputs into the {cout,s} result word
   always_comb begin
      res_d = {w_cy, w_sum};
   end

   // Output register; reset clears immediately and wins over a coincident edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else begin
         res_q <= res_d;
      end
   end

   assign s    = res_q[0];
   assign cout = res_q[1];

`ifdef FAS_CHECK_EN
   fas_res_t exp_d;
   fas_res_t exp_q;
   logic     armed_d;
   logic     armed_q;

   // Behavioural expectation from the raw inputs, independent of the gates
   always_comb begin
      exp_d   = fas_ref(a, b, cin, a_ns);
      armed_d = 1'b1;
   end

   // Expectation register tracks the output register; armed_q skips the
   // first edge after reset release, when the outputs still hold reset zeros
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         exp_q   <= exp_d;
         armed_q <= armed_d;
      end
   end

   // Compare the previous capture against its expectation on every live edge
   always @(posedge clk) begin
      if (rst_n && armed_q && (res_q !== exp_q)) begin
         $error("fas_cell check: {cout,s}=%b expected %b", res_q, exp_q);
      end
   end
`endif

endmodule : fas_cell
`default_nettype wire

// File: tb/tb_fas_cell.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fas_cell
//  Description : Self-checking bench for fas_cell: reset behaviour, directed
//                and exhaustive vector table, random vectors against an
//                arithmetic model, gate-delay probes and async reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fas_cell;

   localparam int CLK_HALF = 50;

   logic clk;
   logic rst_n;
   logic a;
   logic b;
   logic cin;
   logic a_ns;
   logic s;
   logic cout;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       a;
      logic       b;
      logic       cin;
      logic       a_ns;
      logic [1:0] exp;
   } vec_t;

   vec_t tbl[20];

   fas_cell u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .a_ns  (a_ns),
      .s     (s),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #(CLK_HALF) clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic model: add operand or its one's complement plus carry in
   function automatic logic [1:0] model(input logic ma, input logic mb,
                                        input logic mc, input logic mns);
      int total;
      total = int'(ma) + (mns ? int'(mb) : 1 - int'(mb)) + int'(mc);
      return total[1:0];
   endfunction

   // Drive at the falling edge, sample 1ns after the following rising edge
   task automatic apply(input logic va, input logic vb, input logic vc,
                        input logic vns, input logic [1:0] exp, input string name);
      @(negedge clk);
      a = va; b = vb; cin = vc; a_ns = vns;
      @(posedge clk);
      #1;
      check(name, {cout, s}, exp);
   endtask

   initial begin
      // Directed cases, then all 16 {a_ns,cin,b,a} codes with hand-computed sums
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b01};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b10};
      //               a     b     cin   a_ns  exp
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b11};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b01};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01};
      tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b01};
      tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b10};
      tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10};
      tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11};

      // Reset held with all inputs high: outputs stay zero, even between edges
      rst_n = 1'b1;
      a = 1'b1; b = 1'b1; cin = 1'b1; a_ns = 1'b1;
      #1 rst_n = 1'b0;
      #19;
      check("reset_before_edge", {cout, s}, 2'b00);
      @(posedge clk);
      #1;
      check("reset_after_edge", {cout, s}, 2'b00);
      #30;
      check("reset_mid_cycle", {cout, s}, 2'b00);
      @(posedge clk);
      #20;
      check("reset_second_cycle", {cout, s}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors, one per cycle
      for (int i = 0; i < 20; i++) begin
         apply(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].a_ns, tbl[i].exp,
               $sformatf("table_%0d", i));
      end

      // Random vectors against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         logic [3:0] r;
         r = 4'($urandom_range(0, 15));
         apply(r[0], r[1], r[2], r[3], model(r[0], r[1], r[2], r[3]),
               $sformatf("random_%0d", i));
      end

      // Gate timing: only b changes, so every XNOR stage and the carry toggle
      apply(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, "timing_setup");
      @(negedge clk);
      b = 1'b1;
      #26;
      check("sum_before_27ns", {1'b0, u_dut.u_core.sum}, 2'b01);
      #2;
      check("sum_after_27ns", {1'b0, u_dut.u_core.sum}, 2'b00);
      #10;
      check("cy_by_37ns", {1'b0, u_dut.u_core.cy}, 2'b01);
      @(posedge clk);
      #1;
      check("timing_registered", {cout, s}, 2'b10);

      // Async reset mid-cycle: outputs clear without a clock edge
      apply(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, "pre_async_reset");
      #24;
      rst_n = 1'b0;
      #1;
      check("async_reset_immediate", {cout, s}, 2'b00);
      @(posedge clk);
      #1;
      check("async_reset_held_edge", {cout, s}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_capture_after_release", {cout, s}, 2'b11);

      // Reset asserted exactly at a capturing edge wins
      apply(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, "pre_edge_reset");
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_on_edge", {cout, s}, 2'b00);
      @(negedge clk);
      check("reset_on_edge_held", {cout, s}, 2'b00);
      rst_n = 1'b1;
      apply(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, "after_edge_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fas_cell
`default_nettype wire
